method_call_driver: RTL and testbench
=====================================

# method_call_driver

Synthesizable caller for a single generated method exposing the req/busy/return handshake, such as a sort self-test. It sits directly upstream of the method under test. After reset it waits a fixed delay, issues the call, waits for completion and samples the boolean return. It repeats this for a set number of iterations and reports pass/fail, a pass count and per-call latency. This lets a bench or an FPGA top get a verdict without a behavioural top.

## Interface
- START_DELAY, 100: cycles in IDLE after reset release before the first call (≥1).
- ITERATIONS, 1: number of calls per run (1..65535).
- ACK_WINDOW, 4: cycles allowed for busy to rise after req.
- TIMEOUT, 200000000: cycles allowed for busy to fall after it rose; 32-bit.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- restart  in  1  one-cycle pulse; starts a new run when in FINISH.
- method_req  out  1  call request to the method.
- method_busy  in  1  method busy flag.
- method_return  in  1  method boolean return; valid when busy has fallen.
- done  out  1  run finished (FINISH state).
- pass  out  1  valid with done; 1 = all ITERATIONS calls returned 1 with no timeout.
- timeout  out  1  valid with done; 1 = the run was aborted by an ACK_WINDOW or TIMEOUT expiry.
- pass_count  out  16  calls that returned 1 in the current run.
- last_cycles  out  32  latency of the most recent completed call.

## Operation
- States: IDLE, REQ, WAIT_ACK, WAIT_DONE, CHECK, FINISH.
- **IDLE:** a delay counter counts START_DELAY cycles, then the block goes to REQ.
- **REQ:**
  - method_req = 1 for exactly one cycle.
  - The latency counter is cleared to 0.
  - Next state is WAIT_ACK.
- **WAIT_ACK:**
  - The latency counter increments every cycle.
  - busy=1 → WAIT_DONE.
  - After ACK_WINDOW cycles without busy → FINISH with timeout=1.
- **WAIT_DONE:**
  - The latency counter increments every cycle.
  - busy=0 → CHECK; method_return is registered on that same edge.
  - If the counter reaches TIMEOUT → FINISH with timeout=1.
- **CHECK (one cycle):**
  - last_cycles ← latency counter.
  - If the registered return = 1, pass_count increments; otherwise a fail flag is set.
  - The iteration counter increments.
  - If the counter equals ITERATIONS → FINISH; else → REQ.
- **FINISH:**
  - done=1.
  - pass = !fail && !timeout && pass_count==ITERATIONS.
  - Outputs hold until restart or reset.
- **restart:**
  - Accepted only in FINISH.
  - Clears pass_count, the fail/timeout flags and the iteration counter.
  - Goes to REQ directly; START_DELAY is not re-applied.
  - restart in any other state is ignored.
- **Widths:**
  - The latency counter saturates at 32'hFFFFFFFF and does not wrap.
  - pass_count is 16 bits and cannot overflow given the ITERATIONS bound.

## Timing
- **Reset values:**
  - method_req=0, done=0, pass=0, timeout=0, pass_count=0, last_cycles=0.
  - State = IDLE with the delay counter cleared.
- **Reset mid-operation:**
  - Asynchronous return to the reset values above.
  - method_req drops immediately.
  - The run is abandoned; there is no verdict.
- **First call:**
  - With reset released before edge 0, method_req is high during the cycle after edge START_DELAY.
- **Busy rising in the same cycle as the req pulse** (combinational ack): that cycle is sampled in WAIT_ACK and counts as ack.
- **Zero-length busy** (busy never seen high): treated as a WAIT_ACK timeout.
- **Latency definition:** last_cycles = number of WAIT_ACK plus WAIT_DONE cycles. For busy rising 1 cycle after req and staying high for K cycles, last_cycles = K+1.
- **Spacing between calls:** the minimum gap from one req to the next is 4 cycles (REQ, WAIT_ACK, WAIT_DONE, CHECK).
- **done:** rises the cycle after CHECK or after the timeout detection; it is registered, not combinational.
- **Verdict outputs:** pass and timeout are meaningful only while done=1 and read 0 otherwise.

## Test plan
- **Single passing call:** START_DELAY=100, ITERATIONS=1; model raises busy 1 cycle after req, holds it 50 cycles, return=1.
  → Exactly one req pulse, last_cycles=51, done=1, pass=1, timeout=0, pass_count=1.
- **Failing return:** same as above with return=0.
  → done=1, pass=0, timeout=0, pass_count=0.
- **Multi-iteration with one failure:** ITERATIONS=3, returns 1, 0, 1.
  → 3 req pulses, pass_count=2, pass=0.
- **Timeouts:**
  - Busy stuck high with TIMEOUT=1000 → timeout=1, done=1, pass=0, with no further req pulses.
  - Busy never rising with ACK_WINDOW=4 → timeout=1 within 5 cycles of req.
- **Restart:** pulse restart while done=1.
  → Counters cleared; req on the next cycle; a second verdict is produced. A restart pulse during WAIT_DONE has no effect.
- **Reset during WAIT_DONE:** assert reset during WAIT_DONE.
  → All outputs return to 0 immediately; after release, the first req follows a fresh START_DELAY.

Source files
------------

// File: rtl/method_call_driver_if.sv
// Request/busy/return handshake between the call driver (master) and the method under test (slave).
interface method_call_driver_if;
    logic method_req;
    logic method_busy;
    logic method_return;

    modport master (
        output method_req,
        input  method_busy,
        input  method_return
    );

    modport slave (
        input  method_req,
        output method_busy,
        output method_return
    );
endinterface

// File: rtl/method_call_driver.sv
// Drives a generated method through a fixed number of calls after a start delay
// and reports pass/fail, the count of passing calls and the latency of the last call.
module method_call_driver #(
    parameter int unsigned START_DELAY = 100,
    parameter int unsigned ITERATIONS  = 1,
    parameter int unsigned ACK_WINDOW  = 4,
    parameter logic [31:0] TIMEOUT     = 32'd200000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restart,
    method_call_driver_if.master bus,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [15:0]          pass_count,
    output logic [31:0]          last_cycles
);

    localparam logic [31:0] DELAY_C    = 32'(START_DELAY);
    localparam logic [15:0] ITER_C     = 16'(ITERATIONS);
    localparam logic [31:0] ACK_LAST_C = 32'(ACK_WINDOW - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_ACK,
        WAIT_DONE,
        CHECK,
        FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] delay_q, delay_d;
    logic [31:0] latency_q, latency_d;
    logic [31:0] lastCycles_q, lastCycles_d;
    logic [15:0] iter_q, iter_d;
    logic [15:0] passCount_q, passCount_d;
    logic        ret_q, ret_d;
    logic        fail_q, fail_d;
    logic        timeout_q, timeout_d;
    logic [31:0] latencyInc;
    logic [15:0] iterInc;

    // Latency saturates rather than wrapping so a huge TIMEOUT never aliases.
    assign latencyInc = (latency_q == 32'hFFFF_FFFF) ? latency_q : latency_q + 32'd1;
    assign iterInc    = iter_q + 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            delay_q      <= '0;
            latency_q    <= '0;
            lastCycles_q <= '0;
            iter_q       <= '0;
            passCount_q  <= '0;
            ret_q        <= 1'b0;
            fail_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            delay_q      <= delay_d;
            latency_q    <= latency_d;
            lastCycles_q <= lastCycles_d;
            iter_q       <= iter_d;
            passCount_q  <= passCount_d;
            ret_q        <= ret_d;
            fail_q       <= fail_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        delay_d      = delay_q;
        latency_d    = latency_q;
        lastCycles_d = lastCycles_q;
        iter_d       = iter_q;
        passCount_d  = passCount_q;
        ret_d        = ret_q;
        fail_d       = fail_q;
        timeout_d    = timeout_q;

        case (state_q)
            IDLE: begin
                if (delay_q == DELAY_C) begin
                    state_d = REQ;
                end else begin
                    delay_d = delay_q + 32'd1;
                end
            end
            REQ: begin
                latency_d = '0;
                state_d   = WAIT_ACK;
            end
            WAIT_ACK: begin
                latency_d = latencyInc;
                if (bus.method_busy) begin
                    state_d = WAIT_DONE;
                end else if (latency_q == ACK_LAST_C) begin
                    timeout_d = 1'b1;
                    state_d   = FINISH;
                end
            end
            WAIT_DONE: begin
                latency_d = latencyInc;
                if (!bus.method_busy) begin
                    ret_d   = bus.method_return;
                    state_d = CHECK;
                end else if (latencyInc >= TIMEOUT) begin
                    timeout_d = 1'b1;
                    state_d   = FINISH;
                end
            end
            CHECK: begin
                lastCycles_d = latency_q;
                if (ret_q) begin
                    passCount_d = passCount_q + 16'd1;
                end else begin
                    fail_d = 1'b1;
                end
                iter_d  = iterInc;
                state_d = (iterInc == ITER_C) ? FINISH : REQ;
            end
            FINISH: begin
                // A restart skips the start delay and goes straight to the next call.
                if (restart) begin
                    passCount_d = '0;
                    fail_d      = 1'b0;
                    timeout_d   = 1'b0;
                    iter_d      = '0;
                    state_d     = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.method_req = (state_q == REQ);
    assign done           = (state_q == FINISH);
    assign pass           = done && !fail_q && !timeout_q && (passCount_q == ITER_C);
    assign timeout        = done && timeout_q;
    assign pass_count     = passCount_q;
    assign last_cycles    = lastCycles_q;

endmodule

// File: tb/tb_method_call_driver.sv
// Directed bench: acts as the method under test and checks verdicts, latency and handshake timing.
module tb_method_call_driver;

    localparam int unsigned START_DELAY = 100;
    localparam int unsigned ITERATIONS  = 3;
    localparam int unsigned ACK_WINDOW  = 4;
    localparam logic [31:0] TIMEOUT     = 32'd1000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        restart = 1'b0;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [15:0] passCount;
    logic [31:0] lastCycles;

    int compared = 0;
    int mismatched = 0;

    method_call_driver_if bus ();

    method_call_driver #(
        .START_DELAY (START_DELAY),
        .ITERATIONS  (ITERATIONS),
        .ACK_WINDOW  (ACK_WINDOW),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .restart     (restart),
        .bus         (bus),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .pass_count  (passCount),
        .last_cycles (lastCycles)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic waitForReq(input int limit, output int cycles);
        cycles = 0;
        while (bus.method_req !== 1'b1 && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("reqSeen", 32'(bus.method_req), 32'd1);
    endtask

    task automatic waitForDone(input int limit, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("doneSeen", 32'(done), 32'd1);
    endtask

    // Entered on the negedge where req is high; busy rises one cycle later and stays high holdCycles cycles.
    task automatic applyStimulus(input int holdCycles, input logic retVal, input bit midRestart);
        @(negedge clk);
        checkOutput("reqWidth", 32'(bus.method_req), 32'd0);
        bus.method_busy = 1'b1;
        if (midRestart) begin
            repeat (2) @(negedge clk);
            restart = 1'b1;
            @(negedge clk);
            restart = 1'b0;
            repeat (holdCycles - 3) @(negedge clk);
        end else begin
            repeat (holdCycles) @(negedge clk);
        end
        bus.method_busy   = 1'b0;
        bus.method_return = retVal;
    endtask

    task automatic pulseRestart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic checkNoReq(input string tag, input int span);
        logic seen;
        seen = 1'b0;
        repeat (span) begin
            @(negedge clk);
            if (bus.method_req !== 1'b0) seen = 1'b1;
        end
        checkOutput(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int cyc;
        bus.method_busy   = 1'b0;
        bus.method_return = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rstReq", 32'(bus.method_req), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstPass", 32'(pass), 32'd0);
        checkOutput("rstTimeout", 32'(timeout), 32'd0);
        checkOutput("rstPassCount", 32'(passCount), 32'd0);
        checkOutput("rstLastCycles", lastCycles, 32'd0);

        // Run 1: three passing calls, an ignored restart during WAIT_DONE.
        reset = 1'b1;
        waitForReq(300, cyc);
        checkOutput("firstReqDelay", 32'(cyc), 32'(START_DELAY + 1));
        applyStimulus(5, 1'b1, 1'b0);
        waitForReq(20, cyc);
        checkOutput("callGap", 32'(cyc), 32'd2);
        applyStimulus(10, 1'b1, 1'b1);
        waitForReq(20, cyc);
        applyStimulus(50, 1'b1, 1'b0);
        waitForDone(20, cyc);
        checkOutput("doneDelay", 32'(cyc), 32'd2);
        checkOutput("run1Pass", 32'(pass), 32'd1);
        checkOutput("run1Timeout", 32'(timeout), 32'd0);
        checkOutput("run1PassCount", 32'(passCount), 32'd3);
        checkOutput("run1LastCycles", lastCycles, 32'd51);
        checkNoReq("run1Hold", 10);
        checkOutput("run1DoneHold", 32'(done), 32'd1);

        // Run 2: returns 1, 0, 1.
        pulseRestart();
        checkOutput("restartReq", 32'(bus.method_req), 32'd1);
        checkOutput("restartDone", 32'(done), 32'd0);
        checkOutput("restartPassCount", 32'(passCount), 32'd0);
        applyStimulus(3, 1'b1, 1'b0);
        waitForReq(20, cyc);
        applyStimulus(4, 1'b0, 1'b0);
        waitForReq(20, cyc);
        applyStimulus(5, 1'b1, 1'b0);
        waitForDone(20, cyc);
        checkOutput("run2Pass", 32'(pass), 32'd0);
        checkOutput("run2Timeout", 32'(timeout), 32'd0);
        checkOutput("run2PassCount", 32'(passCount), 32'd2);
        checkOutput("run2LastCycles", lastCycles, 32'd6);

        // Run 3: every call returns 0 with a one-cycle busy.
        pulseRestart();
        applyStimulus(1, 1'b0, 1'b0);
        waitForReq(20, cyc);
        applyStimulus(1, 1'b0, 1'b0);
        waitForReq(20, cyc);
        applyStimulus(1, 1'b0, 1'b0);
        waitForDone(20, cyc);
        checkOutput("run3Pass", 32'(pass), 32'd0);
        checkOutput("run3Timeout", 32'(timeout), 32'd0);
        checkOutput("run3PassCount", 32'(passCount), 32'd0);
        checkOutput("run3LastCycles", lastCycles, 32'd2);

        // Run 4: busy never rises.
        pulseRestart();
        checkOutput("run4Req", 32'(bus.method_req), 32'd1);
        waitForDone(10, cyc);
        checkOutput("ackTimeoutDelay", 32'(cyc), 32'd5);
        checkOutput("run4Timeout", 32'(timeout), 32'd1);
        checkOutput("run4Pass", 32'(pass), 32'd0);
        checkOutput("run4LastCycles", lastCycles, 32'd2);
        checkNoReq("run4NoReq", 20);

        // Run 5: busy stuck high.
        pulseRestart();
        @(negedge clk);
        bus.method_busy = 1'b1;
        waitForDone(1100, cyc);
        checkOutput("busyTimeoutDelay", 32'(cyc), 32'(TIMEOUT));
        checkOutput("run5Timeout", 32'(timeout), 32'd1);
        checkOutput("run5Pass", 32'(pass), 32'd0);
        checkOutput("run5PassCount", 32'(passCount), 32'd0);
        checkNoReq("run5NoReq", 20);
        bus.method_busy = 1'b0;

        // Run 6: reset while the second call is in WAIT_DONE.
        pulseRestart();
        applyStimulus(5, 1'b1, 1'b0);
        waitForReq(20, cyc);
        @(negedge clk);
        bus.method_busy = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("preResetPassCount", 32'(passCount), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("midRstReq", 32'(bus.method_req), 32'd0);
        checkOutput("midRstDone", 32'(done), 32'd0);
        checkOutput("midRstPassCount", 32'(passCount), 32'd0);
        checkOutput("midRstLastCycles", lastCycles, 32'd0);
        @(negedge clk);
        bus.method_busy = 1'b0;
        reset = 1'b1;
        waitForReq(300, cyc);
        checkOutput("reqAfterReset", 32'(cyc), 32'(START_DELAY + 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
